row_scan_decoder: RTL and testbench
===================================

Name: row_scan_decoder

Overview:
Parametrised, registered successor to the fixed 3-to-8 row decoder in the vending-machine keypad/display path. It drives a one-hot row-select bus in two modes:
- Direct mode: registered decode of an external address.
- Scan mode: autonomous, with a programmable dwell time per row, a hold input to freeze the scan while a key is debounced, and a frame-done pulse.
It sits between the controller FSM and the keypad/display row drivers.

Parameters:
ADDR_W, 3, width of address and row_index.
ROWS, 8, number of physical rows; legal range 2..2**ADDR_W.
DWELL, 4, clock cycles spent on each row in scan mode; minimum 1.
ACTIVE_LOW, 0, 1 inverts row_select polarity (selected row = 0, others = 1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  block enable; 0 forces IDLE.
mode  input  1  0 = direct decode, 1 = auto scan.
address  input  ADDR_W  row to select in direct mode.
hold  input  1  scan mode only: freeze on the current row.
row_select  output  ROWS  one-hot (or one-cold if ACTIVE_LOW) row drive, registered.
row_index  output  ADDR_W  binary index of the currently driven row, registered.
row_valid  output  1  1 when exactly one row is driven.
frame_done  output  1  single-cycle pulse when scan wraps from row ROWS-1 to row 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, row_select all inactive (0s, or 1s when ACTIVE_LOW), row_index=0, row_valid=0, frame_done=0, dwell counter=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, DIRECT, SCAN. Each cycle the next state is chosen as follows:
  - en=0 -> IDLE.
  - en=1 and mode=0 -> DIRECT.
  - en=1 and mode=1 -> SCAN.
- IDLE: outputs inactive as at reset; dwell counter cleared.
- DIRECT:
  - Latency is 1 cycle from address to row_select, row_index and row_valid.
  - address < ROWS: bit [address] active, row_index=address, row_valid=1.
  - address >= ROWS: all rows inactive, row_valid=0, row_index=0.
  - frame_done=0 throughout.
- SCAN entry (from IDLE or DIRECT): the first SCAN cycle drives row 0, sets row_valid=1 and clears the dwell counter.
- SCAN operation:
  - The dwell counter counts 0..DWELL-1.
  - On the cycle where the counter equals DWELL-1 and hold=0, the row advances on the next edge: row_index+1, or 0 after ROWS-1.
  - The counter then returns to 0.
  - Each row is therefore driven for exactly DWELL cycles.
  - DWELL=1 advances every cycle.
- Wrap: frame_done is high for exactly the first cycle in which row 0 is driven after row ROWS-1. It is not asserted on SCAN entry.
- hold=1 in SCAN:
  - The dwell counter and row_index freeze; row_select remains driven.
  - When hold is released, counting resumes from the frozen count.
  - hold is ignored in IDLE and DIRECT.
- Mode change mid-scan (mode 1->0): the next cycle is DIRECT and shows the decode of address. Scan position is discarded; re-entering SCAN restarts at row 0.
- en deasserted mid-operation: the next cycle is IDLE with outputs inactive.
- Reset asserted mid-operation: outputs go inactive immediately, without waiting for a clock edge.
- Invariant: at most one row_select bit is active in any cycle; row_valid=1 iff exactly one is active.
- ACTIVE_LOW affects only the row_select output polarity; all internal logic and other outputs are unchanged.

Test Plan:
- Reset/direct sweep: ROWS=8, DWELL=4, ACTIVE_LOW=0. Assert rst, then en=1, mode=0, address=5 -> one cycle later row_select=8'b0010_0000, row_index=5, row_valid=1. Step address 0..7 -> one-hot follows with 1-cycle latency.
- Out of range: ROWS=6, ADDR_W=3, direct mode, address=6 and 7 -> row_select=6'b000000, row_valid=0.
- Scan timing: ROWS=8, DWELL=4, mode=1 for 40 cycles -> rows 0..7 each held 4 cycles. frame_done pulses once, on cycle 32 after entry, coincident with row 0 re-driven. Never on entry.
- Hold: in scan, assert hold for 10 cycles at dwell count 2 of row 3 -> row 3 held 10 extra cycles. After release, row 3 lasts 2 more cycles, then row 4.
- Mode/en changes: mid-scan at row 6 switch mode=0 with address=1 -> next cycle row 1. Set mode=1 -> scan restarts at row 0. Drop en -> next cycle all rows inactive.
- Async reset and polarity: ACTIVE_LOW=1, assert rst mid-scan between edges -> row_select=all 1s immediately and row_valid=0. Every cycle, check the invariant that at most one bit is active.

Source files
------------

// File: rtl/row_scan_decoder.sv
// row_scan_decoder: registered one-hot row driver with direct decode and timed auto-scan.
// All outputs come straight from flops; next values are computed from inputs and current state.
module row_scan_decoder #(
    parameter int ADDR_W     = 3,
    parameter int ROWS       = 8,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [ADDR_W-1:0] address,
    input  logic              hold,
    output logic [ROWS-1:0]   row_select,
    output logic [ADDR_W-1:0] row_index,
    output logic              row_valid,
    output logic              frame_done
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [ADDR_W:0]   ROWS_X   = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [CW-1:0]     LAST_CNT = CW'(DWELL - 1);
    localparam logic [ROWS-1:0]   POL      = ACTIVE_LOW != 0 ? '1 : '0;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     dwell_q, dwell_d;
    logic [ADDR_W-1:0] row_index_q, row_index_d;
    logic              row_valid_q, row_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [ROWS-1:0]   row_select_q, row_select_d;
    logic              adv, last;

    always_comb begin
        state_d      = !en ? IDLE : (mode ? SCAN : DIRECT);
        dwell_d      = '0;
        row_index_d  = '0;
        row_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        adv          = !hold && dwell_q == LAST_CNT;
        last         = row_index_q == LAST_ROW;
        if (state_d == DIRECT) begin
            row_valid_d = {1'b0, address} < ROWS_X;
            row_index_d = row_valid_d ? address : '0;
        end else if (state_d == SCAN) begin
            row_valid_d = 1'b1;
            // Entering scan leaves everything at row 0 / count 0 with no frame pulse.
            if (state_q == SCAN) begin
                dwell_d      = hold ? dwell_q : (adv ? '0 : dwell_q + 1'b1);
                row_index_d  = adv ? (last ? '0 : row_index_q + 1'b1) : row_index_q;
                frame_done_d = adv && last;
            end
        end
        row_select_d = (row_valid_d ? ROWS'(1) << row_index_d : '0) ^ POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dwell_q      <= '0;
            row_index_q  <= '0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            row_select_q <= POL;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            row_index_q  <= row_index_d;
            row_valid_q  <= row_valid_d;
            frame_done_q <= frame_done_d;
            row_select_q <= row_select_d;
        end
    end

    assign row_select = row_select_q;
    assign row_index  = row_index_q;
    assign row_valid  = row_valid_q;
    assign frame_done = frame_done_q;

    assert property (@(posedge clk) disable iff (rst)
        $onehot0(row_select_q ^ POL) && row_valid_q == $onehot(row_select_q ^ POL));
endmodule

// File: tb/tb_row_scan_decoder.sv
// tb_row_scan_decoder: directed checks of direct decode, scan timing, hold, mode/en changes and async reset.
module tb_row_scan_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, mode = 1'b0, hold = 1'b0;
    logic [2:0] address = '0;
    logic [7:0] s8, sl;
    logic [5:0] s6;
    logic [2:0] i8, i6, il;
    logic       v8, v6, vl, f8, f6, fl;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    row_scan_decoder #(.ADDR_W(3), .ROWS(8), .DWELL(4), .ACTIVE_LOW(0)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .address(address), .hold(hold),
        .row_select(s8), .row_index(i8), .row_valid(v8), .frame_done(f8));
    row_scan_decoder #(.ADDR_W(3), .ROWS(6), .DWELL(1), .ACTIVE_LOW(0)) u6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .address(address), .hold(hold),
        .row_select(s6), .row_index(i6), .row_valid(v6), .frame_done(f6));
    row_scan_decoder #(.ADDR_W(3), .ROWS(8), .DWELL(4), .ACTIVE_LOW(1)) ul (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .address(address), .hold(hold),
        .row_select(sl), .row_index(il), .row_valid(vl), .frame_done(fl));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        checks++;
        if ($countones(s8) > 1 || v8 !== ($countones(s8) == 1)) begin
            errors++;
            $display("FAIL invariant_u8 row_select=%b row_valid=%b", s8, v8);
        end
        checks++;
        if ($countones(~sl) > 1 || vl !== ($countones(~sl) == 1)) begin
            errors++;
            $display("FAIL invariant_ul row_select=%b row_valid=%b", sl, vl);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({s8, i8, v8, f8} !== 13'b0) begin
            errors++;
            $display("FAIL reset_u8 got sel=%b idx=%0d valid=%b fd=%b want all 0", s8, i8, v8, f8);
        end
        checks++;
        if (sl !== 8'hff || vl !== 1'b0) begin
            errors++;
            $display("FAIL reset_ul got sel=%b valid=%b want 11111111/0", sl, vl);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_direct();
        logic [7:0] exp;
        en = 1'b1;
        mode = 1'b0;
        address = 3'd5;
        step();
        checks++;
        if (s8 !== 8'b0010_0000 || i8 !== 3'd5 || v8 !== 1'b1) begin
            errors++;
            $display("FAIL direct5 got sel=%b idx=%0d valid=%b want 00100000/5/1", s8, i8, v8);
        end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            exp = 8'b1 << a;
            step();
            checks++;
            if (s8 !== exp || i8 !== 3'(a) || v8 !== 1'b1 || f8 !== 1'b0) begin
                errors++;
                $display("FAIL direct_sweep a=%0d got sel=%b idx=%0d valid=%b fd=%b want %b", a, s8, i8, v8, f8, exp);
            end
            checks++;
            if (sl !== ~exp) begin
                errors++;
                $display("FAIL direct_low a=%0d got %b want %b", a, sl, ~exp);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int a = 6; a < 8; a++) begin
            address = 3'(a);
            step();
            checks++;
            if (s6 !== 6'b000000 || v6 !== 1'b0 || i6 !== 3'd0) begin
                errors++;
                $display("FAIL out_of_range a=%0d got sel=%b valid=%b idx=%0d want 000000/0/0", a, s6, v6, i6);
            end
        end
        address = 3'd5;
        step();
        checks++;
        if (s6 !== 6'b100000 || v6 !== 1'b1) begin
            errors++;
            $display("FAIL top_row got sel=%b valid=%b want 100000/1", s6, v6);
        end
    endtask

    task automatic test_scan();
        int pulses = 0;
        en = 1'b0;
        step();
        en = 1'b1;
        mode = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            pulses += int'(f8);
            checks++;
            if (i8 !== 3'((c / 4) % 8) || s8 !== 8'b1 << ((c / 4) % 8) || v8 !== 1'b1 || f8 !== (c == 32)) begin
                errors++;
                $display("FAIL scan c=%0d got idx=%0d sel=%b fd=%b want idx=%0d fd=%b", c, i8, s8, f8, (c / 4) % 8, c == 32);
            end
            checks++;
            if (i6 !== 3'(c % 6) || f6 !== (c > 0 && c % 6 == 0)) begin
                errors++;
                $display("FAIL scan_dwell1 c=%0d got idx=%0d fd=%b want idx=%0d", c, i6, f6, c % 6);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL frame_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        step();
        en = 1'b1;
        for (int c = 0; c <= 14; c++) step();
        checks++;
        if (i8 !== 3'd3) begin
            errors++;
            $display("FAIL hold_start got idx=%0d want 3", i8);
        end
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (i8 !== 3'd3 || s8 !== 8'b0000_1000) begin
                errors++;
                $display("FAIL hold_frozen k=%0d got idx=%0d sel=%b want 3", k, i8, s8);
            end
        end
        hold = 1'b0;
        step();
        checks++;
        if (i8 !== 3'd3) begin
            errors++;
            $display("FAIL hold_release got idx=%0d want 3", i8);
        end
        step();
        checks++;
        if (i8 !== 3'd4 || f8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_advance got idx=%0d fd=%b want 4/0", i8, f8);
        end
        mode = 1'b0;
        hold = 1'b1;
        address = 3'd2;
        step();
        address = 3'd4;
        step();
        checks++;
        if (i8 !== 3'd4 || s8 !== 8'b0001_0000) begin
            errors++;
            $display("FAIL hold_direct got idx=%0d sel=%b want 4", i8, s8);
        end
        hold = 1'b0;
    endtask

    task automatic test_mode_change();
        mode = 1'b1;
        for (int c = 0; c <= 24; c++) step();
        checks++;
        if (i8 !== 3'd6) begin
            errors++;
            $display("FAIL reach_row6 got idx=%0d want 6", i8);
        end
        mode = 1'b0;
        address = 3'd1;
        step();
        checks++;
        if (i8 !== 3'd1 || s8 !== 8'b0000_0010 || v8 !== 1'b1 || f8 !== 1'b0) begin
            errors++;
            $display("FAIL mode_to_direct got idx=%0d sel=%b valid=%b fd=%b want 1", i8, s8, v8, f8);
        end
        mode = 1'b1;
        step();
        checks++;
        if (i8 !== 3'd0 || s8 !== 8'b0000_0001 || f8 !== 1'b0) begin
            errors++;
            $display("FAIL rescan_entry got idx=%0d sel=%b fd=%b want 0/00000001/0", i8, s8, f8);
        end
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (i8 !== 3'd1) begin
            errors++;
            $display("FAIL rescan_advance got idx=%0d want 1", i8);
        end
        en = 1'b0;
        step();
        checks++;
        if (s8 !== 8'b0 || v8 !== 1'b0 || i8 !== 3'd0 || sl !== 8'hff) begin
            errors++;
            $display("FAIL en_drop got sel=%b valid=%b idx=%0d selL=%b want idle", s8, v8, i8, sl);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        mode = 1'b1;
        for (int c = 0; c <= 5; c++) step();
        checks++;
        if (il !== 3'd1 || sl !== 8'b1111_1101) begin
            errors++;
            $display("FAIL low_scan got idx=%0d sel=%b want 1/11111101", il, sl);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (sl !== 8'hff || vl !== 1'b0 || il !== 3'd0 || s8 !== 8'b0 || v8 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got selL=%b validL=%b idx=%0d sel8=%b want 11111111/0/0/0", sl, vl, il, s8);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (il !== 3'd0 || sl !== 8'b1111_1110 || vl !== 1'b1 || fl !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_scan got idx=%0d sel=%b valid=%b fd=%b want 0/11111110/1/0", il, sl, vl, fl);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_out_of_range();
        test_scan();
        test_hold();
        test_mode_change();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
